// File: rtl/mc_mem_responder.sv
// -----------------------------------------------------------------------------
// mc_mem_responder
//
// Unified instruction/data memory for the multi-cycle MIPS core. The core
// raises req with its access, the memory latches the access, counts out
// WAIT_STATES wait cycles and then produces a single-cycle response strobe.
// This gives the core a realistic variable-latency memory port.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   WAIT_STATES  extra cycles between acceptance and response (0..15)
//   AW           word-index width, log2(DEPTH_WORDS)
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset
//   req    in   access request, held high by the core until ready
//   we     in   1 = write, 0 = read (sampled at acceptance)
//   addr   in   byte address (sampled at acceptance)
//   be     in   write byte enables, be[0] = bits 7:0 (sampled at acceptance)
//   wdata  in   write data (sampled at acceptance)
//   rdata  out  read data, non-zero only in the response cycle of a good read
//   ready  out  one-cycle response strobe
//   err    out  access fault flag, only ever high together with ready
// -----------------------------------------------------------------------------
module mc_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 1,
    parameter int AW          = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    // First byte address past the end of the array.
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WS_LOAD    = 4'(WAIT_STATES);
    localparam bit          HAS_WAIT   = (WAIT_STATES > 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // An access faults when it is not word aligned or falls past the array.
    function automatic logic addr_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= ADDR_LIMIT);
    endfunction

    function automatic logic [AW-1:0] word_index(input logic [31:0] a);
        return a[AW+1:2];
    endfunction

    // Replace only the enabled bytes of the old word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  byte_en);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state_r;
    logic [3:0]    cnt_r;
    logic          we_r;
    logic [31:0]   addr_r;
    logic [3:0]    be_r;
    logic [31:0]   wdata_r;
    logic [31:0]   rdata_r;
    logic          ready_r;
    logic          err_r;
    logic [31:0]   mem_r [DEPTH_WORDS];

    // Combinational helpers
    logic          src_we_s;
    logic [31:0]   src_addr_s;
    logic          src_fault_s;
    logic [AW-1:0] src_idx_s;
    logic          enter_resp_s;
    logic          cur_fault_s;
    logic          commit_s;

    // Select the access that the upcoming response belongs to: when the
    // response follows acceptance directly (no wait states) the latches are
    // being loaded on the same edge, so the live inputs are used instead.
    always_comb begin
        src_we_s     = we_r;
        src_addr_s   = addr_r;
        enter_resp_s = 1'b0;
        if (state_r == ST_IDLE) begin
            src_we_s     = we;
            src_addr_s   = addr;
            enter_resp_s = req && !HAS_WAIT;
        end else if (state_r == ST_WAIT) begin
            src_we_s     = we_r;
            src_addr_s   = addr_r;
            enter_resp_s = (cnt_r <= 4'd1);
        end else begin
            src_we_s     = we_r;
            src_addr_s   = addr_r;
            enter_resp_s = 1'b0;
        end
        src_fault_s = addr_fault(src_addr_s);
        src_idx_s   = word_index(src_addr_s);
    end

    // Write commit condition for the edge that closes the response cycle.
    always_comb begin
        cur_fault_s = addr_fault(addr_r);
        if (state_r == ST_RESP) begin
            commit_s = we_r && !cur_fault_s;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Access FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            addr_r  <= 32'd0;
            be_r    <= 4'd0;
            wdata_r <= 32'd0;
            rdata_r <= 32'd0;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            // Outputs are high only in the cycle following enter_resp_s,
            // which is exactly the RESP cycle.
            ready_r <= enter_resp_s;
            err_r   <= enter_resp_s && src_fault_s;
            if (enter_resp_s && !src_we_s && !src_fault_s) begin
                rdata_r <= mem_r[src_idx_s];
            end else begin
                rdata_r <= 32'd0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        we_r    <= we;
                        addr_r  <= addr;
                        be_r    <= be;
                        wdata_r <= wdata;
                        cnt_r   <= WS_LOAD;
                        state_r <= HAS_WAIT ? ST_WAIT : ST_RESP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // <= 1 rather than == 1 so a corrupted zero count
                    // still drains to RESP instead of wrapping.
                    if (cnt_r <= 4'd1) begin
                        cnt_r   <= 4'd0;
                        state_r <= ST_RESP;
                    end else begin
                        cnt_r   <= cnt_r - 4'd1;
                        state_r <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    // Memory array write port; contents intentionally survive reset.
    // An async reset during RESP forces the FSM to IDLE immediately, which
    // drops commit_s before the next edge and aborts the write.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_r[word_index(addr_r)] <= merge_bytes(mem_r[word_index(addr_r)], wdata_r, be_r);
        end
    end

    assign rdata = rdata_r;
    assign ready = ready_r;
    assign err   = err_r;

endmodule
